// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the fetch stage and the pipeline
// registers it drives.
//   UPD_*          : pipeline-register update commands (hold / load / flush)
//   fetch_state_t  : fetch-stage control state
package fetch_stage_pkg;

    localparam logic [1:0] UPD_HOLD  = 2'b00;
    localparam logic [1:0] UPD_LOAD  = 2'b01;
    localparam logic [1:0] UPD_FLUSH = 2'b10;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, drives a 1-cycle-latency
// instruction BRAM and presents each fetched word with its PC and the update
// command for the fetch/decode register.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   stall, redirect, halt control from hazard unit / execute / decode
//   redirect_pc           redirect target byte address (bits [1:0] ignored)
//   imem_en, imem_addr    BRAM read enable and word address
//   imem_rdata            BRAM data, valid the cycle after the address
//   f_pc, f_inst, f_valid presented instruction
//   fd_update             fetch/decode register command (hold/load/flush)
//   fetch_count           number of cycles with fd_update = load
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   halt,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            f_pc,
    output logic [31:0]            f_inst,
    output logic                   f_valid,
    output logic [1:0]             fd_update,
    output logic [31:0]            fetch_count
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;          // next address to read
    logic [31:0]  r_f_pc;        // address whose data is on imem_rdata
    logic [31:0]  r_fetch_count;

    fetch_state_t w_state_nxt;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_f_pc_nxt;
    logic         w_cnt_inc;
    logic [31:0]  w_redir_pc;
    logic         w_unused;

    assign w_redir_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused   = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_f_pc        <= RESET_PC;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_f_pc        <= w_f_pc_nxt;
            r_fetch_count <= r_fetch_count + {31'd0, w_cnt_inc};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_f_pc_nxt  = r_f_pc;
        w_cnt_inc   = 1'b0;
        imem_en     = 1'b0;
        imem_addr   = r_pc[IMEM_ADDR_W+1:2];
        fd_update   = UPD_FLUSH;
        case (r_state)
            ST_BOOT: begin
                imem_en     = 1'b1;
                w_pc_nxt    = r_pc + 32'd4;
                w_f_pc_nxt  = r_pc;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    // Any halt seen alongside a redirect is on the wrong path.
                    imem_en    = 1'b1;
                    imem_addr  = redirect_pc[IMEM_ADDR_W+1:2];
                    w_pc_nxt   = w_redir_pc + 32'd4;
                    w_f_pc_nxt = w_redir_pc;
                end else if (halt) begin
                    w_state_nxt = ST_HALT;
                end else if (stall) begin
                    // BRAM enable low keeps the current word on imem_rdata.
                    fd_update = UPD_HOLD;
                end else begin
                    imem_en    = 1'b1;
                    fd_update  = UPD_LOAD;
                    w_pc_nxt   = r_pc + 32'd4;
                    w_f_pc_nxt = r_pc;
                    w_cnt_inc  = 1'b1;
                end
            end
            default: ;  // ST_HALT: flush forever, left only by reset
        endcase
        if (rst) begin
            imem_en   = 1'b0;
            fd_update = UPD_FLUSH;
        end
    end

    assign f_valid     = (r_state == ST_RUN) && !redirect && !rst;
    assign f_pc        = f_valid ? r_f_pc : 32'd0;
    assign f_inst      = f_valid ? imem_rdata : 32'd0;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + randomized bench for fetch_stage against a
// PC-level reference model (which instruction is presented, and what the
// fetch/decode register should do with it).
module tb_fetch_stage;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst, stall, redirect, halt;
    logic [31:0]   redirect_pc;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = 32'd0;
    logic [31:0]   f_pc, f_inst, fetch_count;
    logic          f_valid;
    logic [1:0]    fd_update;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 = booting, 1 = running, 2 = halted.
    int          m_phase;
    logic [31:0] m_pc;   // PC of the instruction being presented
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .imem_en(imem_en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .f_pc(f_pc),
        .f_inst(f_inst), .f_valid(f_valid), .fd_update(fd_update),
        .fetch_count(fetch_count)
    );

    // BRAM: word k holds 0x1000_0000 + k; output holds while disabled.
    always @(posedge clk)
        if (imem_en) imem_rdata <= 32'h1000_0000 + {18'd0, imem_addr};

    function automatic logic [31:0] inst_at(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h3FFF);
    endfunction

    function automatic logic [31:0] waddr(input logic [31:0] pc);
        return (pc >> 2) & 32'h3FFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 32'h0;
        m_cnt   = 32'd0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, clock.
    task automatic step(input logic s, input logic r, input logic h, input logic [31:0] rpc);
        logic        ev, een;
        logic [1:0]  eu;
        logic [31:0] ea, tgt;
        @(negedge clk);
        stall = s; redirect = r; halt = h; redirect_pc = rpc;
        #1;
        tgt = {rpc[31:2], 2'b00};
        ev  = (m_phase == 1) && !r;
        een = 1'b0; ea = 32'd0; eu = 2'b10;
        if (m_phase == 0) begin
            een = 1'b1; ea = waddr(m_pc);
        end else if (m_phase == 1) begin
            if (r)      begin een = 1'b1; ea = waddr(tgt); end
            else if (h) eu = 2'b10;
            else if (s) eu = 2'b00;
            else        begin een = 1'b1; ea = waddr(m_pc + 32'd4); eu = 2'b01; end
        end
        chk("f_valid",     {31'd0, f_valid},   {31'd0, ev});
        chk("f_pc",        f_pc,               ev ? m_pc : 32'd0);
        chk("f_inst",      f_inst,             ev ? inst_at(m_pc) : 32'd0);
        chk("fd_update",   {30'd0, fd_update}, {30'd0, eu});
        chk("imem_en",     {31'd0, imem_en},   {31'd0, een});
        if (een) chk("imem_addr", {18'd0, imem_addr}, ea);
        chk("fetch_count", fetch_count,        m_cnt);
        @(posedge clk);
        if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) begin
            if (r)      m_pc = tgt;
            else if (h) m_phase = 2;
            else if (!s) begin m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1; end
        end
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_fd_update", {30'd0, fd_update}, 32'd2);
        chk("rst_imem_en",   {31'd0, imem_en},   32'd0);
        chk("rst_f_valid",   {31'd0, f_valid},   32'd0);
        chk("rst_count",     fetch_count,        32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Boot, then f_pc = 0, 4; stall 3 cycles at f_pc = 8; load 8.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        adv(2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        adv(1);
        // Redirect to 0x40 while f_pc = 12.
        step(1'b0, 1'b1, 1'b0, 32'h40);
        adv(2);
        // Redirect beats concurrent halt and stall; misaligned target.
        step(1'b1, 1'b1, 1'b1, 32'h23);
        adv(2);

        // Randomized run; halt only ever appears together with redirect.
        for (int i = 0; i < 300; i++) begin
            logic r, h, s;
            r = ($urandom_range(0, 7) == 0);
            h = r ? 1'($urandom_range(0, 1)) : 1'b0;
            s = ($urandom_range(0, 3) == 0);
            step(s, r, h, $urandom);
        end

        // PC wrap from 0xFFFF_FFFC to 0.
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        adv(3);

        // Asynchronous reset between edges.
        @(negedge clk);
        stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_fd_update", {30'd0, fd_update}, 32'd2);
        chk("arst_imem_en",   {31'd0, imem_en},   32'd0);
        chk("arst_f_valid",   {31'd0, f_valid},   32'd0);
        chk("arst_count",     fetch_count,        32'd0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;

        // Reboot, go to 0x20, halt there; redirect pulses must be ignored.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        adv(3);
        step(1'b0, 1'b1, 1'b0, 32'h20);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 20; i++)
            step(1'(i % 2), 1'(i % 3 == 0), 1'b0, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
